// File: rtl/regfile_bypass_sb_pkg.sv
// regfile_bypass_sb_pkg
//   Shared definitions for the register file with bypass and scoreboard:
//   the FSM state encoding and the default geometry constants.
package regfile_bypass_sb_pkg;

    // Clear sweep after reset, then normal operation.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_NUM_RD = 3;

endpackage

// File: rtl/regfile_bypass_sb_read_port.sv
// rf_read_port
//   One combinational read port of the register file.
//   Ports:
//     run       in   1       high when the file is out of its clear sweep
//     addr      in   ADDR_W  register being read
//     reg_data  in   DATA_W  stored value of the addressed register
//     reg_busy  in   1       scoreboard bit of the addressed register
//     wr_en     in   1       writeback enable (same cycle)
//     wr_addr   in   ADDR_W  writeback destination
//     wr_data   in   DATA_W  writeback data
//     data      out  DATA_W  read data (bypassed when writeback hits)
//     busy      out  1       pending write not satisfied this cycle
module rf_read_port
    import regfile_bypass_sb_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              run,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              reg_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    logic is_zero_s;
    assign is_zero_s = (ZERO_REG != 32'sd0) && (addr == {ADDR_W{1'b0}});

    // Select zero, the in-flight writeback value, or the stored value.
    always_comb begin
        data = {DATA_W{1'b0}};
        busy = 1'b0;
        if (!run) begin
            // Contents are undefined until swept; present zero and idle.
            data = {DATA_W{1'b0}};
            busy = 1'b0;
        end else if (is_zero_s) begin
            data = {DATA_W{1'b0}};
            busy = 1'b0;
        end else if (wr_en && (wr_addr == addr)) begin
            // Writeback satisfies the pending write in this very cycle.
            data = wr_data;
            busy = 1'b0;
        end else begin
            data = reg_data;
            busy = reg_busy;
        end
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb
//   Integer register file with NUM_RD combinational read ports, one
//   synchronous write port with write-to-read bypass, a per-register
//   pending-write scoreboard, and a post-reset clear sweep.
//   Ports:
//     clk      in   1              rising-edge clock
//     reset    in   1              synchronous active-high reset
//     rd_addr  in   NUM_RD*ADDR_W  packed read addresses (port i at i*ADDR_W)
//     rd_data  out  NUM_RD*DATA_W  packed read data, combinational
//     rd_busy  out  NUM_RD         per-port pending-write flag
//     wr_en    in   1              writeback enable
//     wr_addr  in   ADDR_W         writeback destination
//     wr_data  in   DATA_W         writeback data
//     iss_en   in   1              issue of an instruction with a destination
//     iss_rd   in   ADDR_W         destination of the issued instruction
//     ready    out  1              high once the clear sweep has finished
module regfile_bypass_sb
    import regfile_bypass_sb_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_rd,
    output logic                     ready
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    rf_state_e         state_r;
    rf_state_e         next_state_s;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic              ready_r;
    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_next_s;

    logic run_s;
    logic wr_zero_s;
    logic iss_zero_s;
    logic wr_commit_s;
    logic iss_commit_s;

    assign run_s        = (state_r == ST_RUN);
    assign wr_zero_s    = (ZERO_REG != 32'sd0) && (wr_addr == {ADDR_W{1'b0}});
    assign iss_zero_s   = (ZERO_REG != 32'sd0) && (iss_rd == {ADDR_W{1'b0}});
    assign wr_commit_s  = run_s && wr_en && !wr_zero_s;
    assign iss_commit_s = run_s && iss_en && !iss_zero_s;
    assign ready        = ready_r;

    // Next-state logic: leave the sweep after the last index is cleared.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_ptr_r == PTR_LAST) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_CLEAR;
                end
            end
            ST_RUN:  next_state_s = ST_RUN;
            default: next_state_s = ST_CLEAR;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Clear-sweep pointer, advances only while sweeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_ptr_r <= {ADDR_W{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            clr_ptr_r <= clr_ptr_r + PTR_ONE;
        end else begin
            clr_ptr_r <= clr_ptr_r;
        end
    end

    // Ready rises on the same edge that enters RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= (next_state_s == ST_RUN);
        end
    end

    // Scoreboard update: writeback clears, issue sets; issue applied last so
    // a same-cycle issue to the written register leaves it busy.
    always_comb begin
        busy_next_s = busy_r;
        if (wr_commit_s) begin
            busy_next_s[wr_addr] = 1'b0;
        end else begin
            busy_next_s = busy_next_s;
        end
        if (iss_commit_s) begin
            busy_next_s[iss_rd] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Storage: the sweep zeroes one entry per cycle, RUN takes writebacks.
    // No reset term on the array itself; the sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_r == ST_CLEAR) begin
                regs_r[clr_ptr_r] <= {DATA_W{1'b0}};
            end else if (wr_commit_s) begin
                regs_r[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        assign addr_s = rd_addr[i*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .run      (run_s),
            .addr     (addr_s),
            .reg_data (regs_r[addr_s]),
            .reg_busy (busy_r[addr_s]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .data     (rd_data[i*DATA_W +: DATA_W]),
            .busy     (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb_regfile_bypass_sb
//   Self-checking bench: reset/sweep timing, a table of directed vectors,
//   a mid-run reset sequence and randomized traffic against a reference model.
module tb_regfile_bypass_sb;

    localparam int DW = 32;
    localparam int DEPTH = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [DW-1:0]    wr_data = '0;
    logic             iss_en = 1'b0;
    logic [AW-1:0]    iss_rd = '0;
    logic             ready;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: architectural contents and pending-write flags.
    logic [DW-1:0] m_regs [DEPTH];
    logic          m_busy [DEPTH];

    regfile_bypass_sb dut (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .iss_en  (iss_en),
        .iss_rd  (iss_rd),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          ie;
        logic [AW-1:0] ia;
        logic [NR*AW-1:0] ra;
        logic [NR*DW-1:0] ed;
        logic [NR-1:0]    eb;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_regs[k] = '0;
            m_busy[k] = 1'b0;
        end
    endtask

    // Architectural effect of one RUN edge with the current inputs.
    task automatic model_update();
        if (wr_en && wr_addr != 0) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    endtask

    task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic b);
        if (a == 0) begin
            d = '0; b = 1'b0;
        end else if (wr_en && wr_addr == a) begin
            d = wr_data; b = 1'b0;
        end else begin
            d = m_regs[a]; b = m_busy[a];
        end
    endtask

    task automatic check_model(input string tag);
        logic [DW-1:0] d;
        logic b;
        for (int p = 0; p < NR; p++) begin
            model_read(rd_addr[p*AW +: AW], d, b);
            chk({tag, "_data"}, rd_data[p*DW +: DW], d);
            chk({tag, "_busy"}, rd_busy[p], b);
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; iss_en = 1'b0; wr_addr = '0; wr_data = '0; iss_rd = '0;
    endtask

    // Count edges until ready rises; 0 means it never did within budget.
    task automatic wait_ready(output int edges);
        edges = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic sweep_zero(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = {NR{AW'(a)}};
            #1;
            chk({tag, "_data"}, rd_data, '0);
            chk({tag, "_busy"}, rd_busy, '0);
        end
    endtask

    vec_t vecs [14];
    int   edges;

    initial begin
        // Directed vectors applied back to back once RUN is reached.
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, {5'd6, 5'd0, 5'd5},
                     {32'h0, 32'h0, 32'hDEADBEEF}, 3'b000};
        vecs[1]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, {5'd5, 5'd5, 5'd5},
                     {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF}, 3'b000};
        vecs[2]  = '{1'b1, 5'd0,  32'h1234, 1'b1, 5'd0, {5'd0, 5'd0, 5'd0},
                     {32'h0, 32'h0, 32'h0}, 3'b000};
        vecs[3]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, {5'd0, 5'd0, 5'd0},
                     {32'h0, 32'h0, 32'h0}, 3'b000};
        vecs[4]  = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd7, {5'd7, 5'd7, 5'd7},
                     {32'h0, 32'h0, 32'h0}, 3'b000};
        vecs[5]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, {5'd0, 5'd5, 5'd7},
                     {32'h0, 32'hDEADBEEF, 32'h0}, 3'b001};
        vecs[6]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, {5'd7, 5'd7, 5'd7},
                     {32'h0, 32'h0, 32'h0}, 3'b111};
        vecs[7]  = '{1'b1, 5'd7,  32'h55, 1'b0, 5'd0, {5'd7, 5'd7, 5'd7},
                     {32'h55, 32'h55, 32'h55}, 3'b000};
        vecs[8]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, {5'd7, 5'd7, 5'd7},
                     {32'h55, 32'h55, 32'h55}, 3'b000};
        vecs[9]  = '{1'b1, 5'd9,  32'hAA, 1'b1, 5'd9, {5'd9, 5'd9, 5'd9},
                     {32'hAA, 32'hAA, 32'hAA}, 3'b000};
        vecs[10] = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, {5'd7, 5'd5, 5'd9},
                     {32'h55, 32'hDEADBEEF, 32'hAA}, 3'b001};
        vecs[11] = '{1'b1, 5'd5,  32'h11, 1'b1, 5'd9, {5'd0, 5'd5, 5'd9},
                     {32'h0, 32'h11, 32'hAA}, 3'b001};
        vecs[12] = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, {5'd0, 5'd5, 5'd9},
                     {32'h0, 32'h11, 32'hAA}, 3'b001};
        vecs[13] = '{1'b1, 5'd12, 32'hC, 1'b0, 5'd0, {5'd5, 5'd9, 5'd12},
                     {32'h11, 32'hAA, 32'hC}, 3'b010};

        model_reset();

        // Reset for three edges.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_in_reset", ready, 1'b0);

        // Release with writeback/issue traffic that the sweep must ignore.
        reset = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hFF;
        iss_en = 1'b1; iss_rd = 5'd2;
        rd_addr = {NR{5'd2}};
        #1;
        chk("clear_rd_data", rd_data, '0);
        chk("clear_rd_busy", rd_busy, '0);
        wait_ready(edges);
        idle_inputs();
        chk("ready_edges", edges, 32);
        sweep_zero("after_sweep");

        // Table-driven directed vectors.
        for (int v = 0; v < 14; v++) begin
            wr_en = vecs[v].we; wr_addr = vecs[v].wa; wr_data = vecs[v].wd;
            iss_en = vecs[v].ie; iss_rd = vecs[v].ia; rd_addr = vecs[v].ra;
            #1;
            chk($sformatf("vec%0d_data", v), rd_data, vecs[v].ed);
            chk($sformatf("vec%0d_busy", v), rd_busy, vecs[v].eb);
            tick();
        end
        idle_inputs();

        // Mid-RUN reset with x3 busy and holding 0x77.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
        tick();
        idle_inputs();
        iss_en = 1'b1; iss_rd = 5'd3;
        tick();
        idle_inputs();
        rd_addr = {NR{5'd3}};
        #1;
        chk("x3_before_reset_data", rd_data, {NR{32'h77}});
        chk("x3_before_reset_busy", rd_busy, 3'b111);
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h99;
        @(posedge clk);
        #1;
        chk("ready_drop", ready, 1'b0);
        reset = 1'b0;
        idle_inputs();
        wait_ready(edges);
        chk("ready_edges_again", edges, 32);
        model_reset();
        sweep_zero("after_resweep");

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            wr_en  = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 7));
            wr_data = $urandom;
            iss_en = 1'($urandom_range(0, 1));
            iss_rd = AW'($urandom_range(0, 7));
            for (int p = 0; p < NR; p++) begin
                if ($urandom_range(0, 3) == 0)
                    rd_addr[p*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
                else
                    rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
            end
            #1;
            check_model("rand");
            chk("rand_ready", ready, 1'b1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Parametrised successor to the pipeline's integer register file.
- Provides NUM_RD combinational read ports, one synchronous write port, and write-to-read bypass, so writeback data is visible in the same cycle.
- Adds a per-register pending-write scoreboard for hazard detection, and a post-reset clear sweep gated by a ready flag.
- Sits between decode (reads and issue) and writeback (write).

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of architectural registers. Power of two, at least 2.
- ADDR_W, $clog2(DEPTH), register address width.
- NUM_RD, 3, number of read ports.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and is never busy.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i is at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  per-port flag: the addressed register has a pending write that is not being satisfied this cycle.
- wr_en  in  1  writeback write enable.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback data.
- iss_en  in  1  issue of an instruction that has a destination register.
- iss_rd  in  ADDR_W  destination of the issued instruction.
- ready  out  1  high once the clear sweep has completed.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- FSM has two states, CLEAR and RUN.
- While reset=1 (sampled at a clk edge):
  - state<=CLEAR, clr_ptr<=0, all busy bits<=0.
  - ready=0 from the first edge with reset high.
- CLEAR state:
  - Each cycle: regs[clr_ptr]<=0, clr_ptr<=clr_ptr+1.
  - After writing index DEPTH-1: state<=RUN.
  - ready is a registered output; it goes 1 on the edge that enters RUN. That is exactly DEPTH edges after the first edge with reset low.
  - wr_en and iss_en are ignored. rd_data reads 0; rd_busy reads 0.
- RUN, write:
  - If wr_en and the write is not to a hardwired zero register: regs[wr_addr]<=wr_data on the clk edge.
  - busy[wr_addr]<=0, unless overridden by an issue to the same address (see below).
- RUN, issue:
  - If iss_en and the target is not a hardwired zero register: busy[iss_rd]<=1.
  - Same cycle wr_en with wr_addr==iss_rd: the issue wins and busy ends 1. The new producer owns the register.
- RUN, reads (combinational, per port i):
  - Hardwired-zero address: data 0, busy 0.
  - Else if wr_en and wr_addr==rd_addr[i]: data=wr_data (bypass), busy=0.
  - Else: data=regs[rd_addr[i]], busy=busy[rd_addr[i]].
- With ZERO_REG=0, register 0 behaves like any other register.
- iss_en with a busy target is legal; the bit stays 1. A write to a non-busy register is legal; the bit stays 0.
- Reset asserted mid-RUN: takes effect at the next edge, ready<=0 and the sweep restarts. Writes on that edge are dropped.
- No other latency: write-to-read is 0 cycles via bypass; issue-to-busy is 1 cycle.

Decomposition:
- Shared package holds:
  - FSM state enum {ST_CLEAR, ST_RUN}.
  - Default parameter constants: RF_DATA_W=32, RF_DEPTH=32, RF_NUM_RD=3.
- The read path is one natural sub-module, rf_read_port, instantiated NUM_RD times in a generate loop.
  - Inputs: address, the register array slice or its mux output, the write-port signals and the busy bit.
  - Outputs: data and busy.
- Storage, scoreboard and FSM stay in the top module.

Test Plan:
- Reset for 3 cycles, then release -> ready=0 for 32 cycles and 1 on the 32nd edge after release. Every rd_addr 0..31 reads 0 and rd_busy=0.
- After ready: write x5=0xDEADBEEF with rd_addr[0]=5 in the same cycle -> rd_data[0]=0xDEADBEEF combinationally (bypass). The next cycle, with wr_en=0, it still reads 0xDEADBEEF.
- Write x0=0x1234, iss_rd=0 with ZERO_REG=1 -> rd_data=0 and rd_busy=0 for address 0 on all ports.
- iss x7, then wait 2 cycles -> rd_busy for address 7 is 1. Then writeback x7=0x55 -> busy=0 that cycle (bypass), and the bit is cleared on the following cycle.
- Same cycle iss x9 and write x9=0xAA -> next cycle the x9 value is 0xAA and rd_busy=1.
- Assert reset for 1 cycle mid-RUN, with x3 busy and holding 0x77 -> ready drops, the sweep runs again, x3 reads 0 and busy=0 once ready returns.
